// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing control slice.
package pipe_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  // Architectural zero register: writes to it never create a dependency.
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the ID/EX load targets a register the IF/ID instruction reads.
module load_use_detect #(
  parameter int unsigned REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  uses_rs2,
  input  logic                  mem_read,
  input  logic [REG_ADDR_W-1:0] rd,
  output logic                  lu
);

  always_comb begin
    lu = 1'b0;
    if (mem_read && (rd != REG_ADDR_W'(pipe_ctrl_pkg::X0)))
      lu = (rd == rs1) || (uses_rs2 && (rd == rs2));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller: load-use stalls, branch redirect flushes, data-memory freezes.
// Optional perf counters (stall_cnt, flush_cnt_total) when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W   = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ifid_rs1,
  input  logic [REG_ADDR_W-1:0] ifid_rs2,
  input  logic                  ifid_uses_rs2,
  input  logic                  idex_mem_read,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  branch_taken,
  input  logic                  dmem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_bubble,
  output logic [1:0]            ctrl_state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt_total
`endif
);
  import pipe_ctrl_pkg::*;

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be in 1..7");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("CNT_W must be at least 1");
  end

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        branch_pending_q, branch_pending_d;
  logic        lu;
  logic        redirect;
  logic        pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .rs1      (ifid_rs1),
    .rs2      (ifid_rs2),
    .uses_rs2 (ifid_uses_rs2),
    .mem_read (idex_mem_read),
    .rd       (idex_rd),
    .lu       (lu)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= RUN;
      flush_cnt_q      <= '0;
      branch_pending_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      branch_pending_q <= branch_pending_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    branch_pending_d = branch_pending_q;
    redirect         = 1'b0;
    pc_write_c       = 1'b1;
    ifid_write_c     = 1'b1;
    ifid_flush_c     = 1'b0;
    idex_bubble_c    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken && dmem_busy) begin
          branch_pending_d = 1'b1;
          state_d          = MEM_WAIT;
          pc_write_c       = 1'b0;
          ifid_write_c     = 1'b0;
        end else if (branch_taken) begin
          redirect = 1'b1;
        end else if (dmem_busy) begin
          state_d      = MEM_WAIT;
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
        end else if (lu) begin
          pc_write_c    = 1'b0;
          ifid_write_c  = 1'b0;
          idex_bubble_c = 1'b1;
        end
      end

      MEM_WAIT: begin
        pc_write_c   = 1'b0;
        ifid_write_c = 1'b0;
        if (dmem_busy) begin
          if (branch_taken)
            branch_pending_d = 1'b1;
        end else if (branch_pending_q || branch_taken) begin
          redirect = 1'b1;
        end else begin
          // Memory released with nothing pending: behave as RUN this very cycle.
          state_d = RUN;
          if (lu) begin
            idex_bubble_c = 1'b1;
          end else begin
            pc_write_c   = 1'b1;
            ifid_write_c = 1'b1;
          end
        end
      end

      FLUSH: begin
        pc_write_c    = !dmem_busy;
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        if (branch_taken)
          flush_cnt_d = FLUSH_RELOAD;
        else if (!dmem_busy && flush_cnt_q != '0)
          flush_cnt_d = flush_cnt_q - 3'd1;
        if (flush_cnt_d == '0)
          state_d = RUN;
      end

      default: begin
        state_d          = RUN;
        flush_cnt_d      = '0;
        branch_pending_d = 1'b0;
        pc_write_c       = 1'b0;
        ifid_write_c     = 1'b0;
        ifid_flush_c     = 1'b1;
        idex_bubble_c    = 1'b1;
      end
    endcase

    // Redirect overrides whatever the state arm chose for this cycle.
    if (redirect) begin
      pc_write_c       = 1'b1;
      ifid_write_c     = 1'b1;
      ifid_flush_c     = 1'b1;
      idex_bubble_c    = 1'b1;
      branch_pending_d = 1'b0;
      flush_cnt_d      = FLUSH_RELOAD;
      state_d          = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
    end
  end

  always_comb begin
    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      ctrl_state  = '0;
    end else begin
      pc_write    = pc_write_c;
      ifid_write  = ifid_write_c;
      ifid_flush  = ifid_flush_c;
      idex_bubble = idex_bubble_c;
      ctrl_state  = state_q;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt       <= '0;
      flush_cnt_total <= '0;
    end else begin
      if (!ifid_write_c && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && flush_cnt_total != '1)
        flush_cnt_total <= flush_cnt_total + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (FLUSH_CYCLES=2): directed pins plus randomized traffic.
module tb_pipe_hazard_ctrl;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic       ifid_uses_rs2 = 1'b0, idex_mem_read = 1'b0;
  logic       branch_taken = 1'b0, dmem_busy = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble;
  logic [1:0] ctrl_state;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt_total;
`endif

  int tests = 0;
  int fails = 0;

  logic       lit_valid = 1'b0;
  logic [5:0] lit_exp = '0;
  string      lit_name = "";

  // Reference state: waiting on memory, redirect owed, flush cycles still to run.
  bit m_wait = 1'b0;
  bit m_pend = 1'b0;
  int m_left = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .ifid_rs1      (ifid_rs1),
    .ifid_rs2      (ifid_rs2),
    .ifid_uses_rs2 (ifid_uses_rs2),
    .idex_mem_read (idex_mem_read),
    .idex_rd       (idex_rd),
    .branch_taken  (branch_taken),
    .dmem_busy     (dmem_busy),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_bubble   (idex_bubble),
    .ctrl_state    (ctrl_state)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .stall_cnt       (stall_cnt),
    .flush_cnt_total (flush_cnt_total)
`endif
  );

  task automatic chk(input string nm, input logic [5:0] got, input logic [5:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got {pc,ifw,flush,bubble,state}=%b required %b", nm, $time, got, exp);
    end
  endtask

  initial begin : compare
    logic [3:0] e;
    logic [1:0] st;
    logic       lu, rdir;
    logic [5:0] got;
    forever begin
      @(negedge clk or posedge reset);
      #1;
      got = {pc_write, ifid_write, ifid_flush, idex_bubble, ctrl_state};
      if (reset) begin
        m_wait = 1'b0;
        m_pend = 1'b0;
        m_left = 0;
        chk("reset_forced", got, 6'b001100);
`ifdef PIPE_HAZARD_PERF_EN
        tests++;
        if (stall_cnt !== '0 || flush_cnt_total !== '0) begin
          fails++;
          $display("FAIL perf_reset: got stall=%0d flush=%0d required 0/0", stall_cnt, flush_cnt_total);
        end
`endif
      end else begin
        lu = idex_mem_read && (idex_rd != 5'd0) &&
             ((idex_rd == ifid_rs1) || (ifid_uses_rs2 && (idex_rd == ifid_rs2)));
        st   = m_wait ? 2'd1 : ((m_left > 0) ? 2'd2 : 2'd0);
        rdir = 1'b0;
        e    = 4'b1100;
        if (m_wait) begin
          if (dmem_busy) begin
            e = 4'b0000;
            if (branch_taken) m_pend = 1'b1;
          end else if (m_pend || branch_taken) begin
            rdir = 1'b1;
          end else begin
            m_wait = 1'b0;
            e = lu ? 4'b0001 : 4'b1100;
          end
        end else if (m_left > 0) begin
          e = {!dmem_busy, 3'b111};
          if (branch_taken) m_left = FC - 1;
          else if (!dmem_busy) m_left = m_left - 1;
        end else if (branch_taken && dmem_busy) begin
          e = 4'b0000; m_wait = 1'b1; m_pend = 1'b1;
        end else if (branch_taken) begin
          rdir = 1'b1;
        end else if (dmem_busy) begin
          e = 4'b0000; m_wait = 1'b1;
        end else begin
          e = lu ? 4'b0001 : 4'b1100;
        end
        if (rdir) begin
          e = 4'b1111; m_left = FC - 1; m_wait = 1'b0; m_pend = 1'b0;
        end
        chk("model", got, {e, st});
        if (lit_valid) chk(lit_name, got, lit_exp);
      end
    end
  end

  task automatic apply(input logic bt, input logic busy, input logic mr, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic u,
                       input logic [5:0] exp, input string nm);
    @(posedge clk);
    #1;
    branch_taken = bt; dmem_busy = busy; idex_mem_read = mr; idex_rd = rd;
    ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_uses_rs2 = u;
    lit_valid = 1'b1; lit_exp = exp; lit_name = nm;
    #2;
  endtask

  task automatic idle(input logic [5:0] exp, input string nm);
    apply(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, exp, nm);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    lit_valid = 1'b0;
    branch_taken = 1'b0; dmem_busy = 1'b0; idex_mem_read = 1'b0;
    idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0; ifid_uses_rs2 = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin : stimulus
    logic bt_prev;
    bt_prev = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    idle(6'b110000, "after_reset");
    apply(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 6'b000100, "lu_rs1_stall");
    idle(6'b110000, "lu_released");
    apply(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 6'b110000, "x0_no_stall");
    apply(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 6'b110000, "rs2_unused");
    apply(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 6'b000100, "rs2_used_stall");

    apply(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b111100, "branch_cycle");
    idle(6'b111110, "branch_flush_state");
    idle(6'b110000, "branch_done");

    apply(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000000, "br_busy_freeze0");
    apply(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000001, "busy_freeze1");
    apply(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000001, "busy_freeze2");
    idle(6'b111101, "busy_fall_redirect");
    idle(6'b111110, "post_busy_flush");
    idle(6'b110000, "post_busy_run");

    apply(1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 6'b111100, "branch_beats_lu");
    apply(1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 6'b111110, "lu_ignored_in_flush");
    idle(6'b110000, "flush_done");

    apply(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b111100, "branch_before_reset");
    idle(6'b111110, "in_flush_before_reset");
    pulse_reset();
    idle(6'b110000, "run_after_flush_reset");

    apply(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000000, "pend_set");
    apply(1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'b000001, "pend_wait");
    pulse_reset();
    idle(6'b110000, "pend_discarded");

    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      lit_valid     = 1'b0;
      branch_taken  = !bt_prev && ($urandom_range(0, 5) == 0);
      bt_prev       = branch_taken;
      dmem_busy     = ($urandom_range(0, 2) == 0);
      idex_mem_read = ($urandom_range(0, 1) == 1);
      idex_rd       = 5'($urandom_range(0, 3));
      ifid_rs1      = 5'($urandom_range(0, 3));
      ifid_rs2      = 5'($urandom_range(0, 3));
      ifid_uses_rs2 = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 79) == 0) begin
        #2;
        pulse_reset();
        bt_prev = 1'b0;
      end
    end

    @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
